// File: rtl/mips_trace_pkg.sv
// Shared types for the MIPS retire monitor: record layout, kind/state enums and the classifier.
package mips_trace_pkg;

  localparam logic [31:0] SYSCALL_INSTR = 32'h0000000C;
  localparam logic [31:0] EXIT_CODE     = 32'd10;
  // Sequence field width stored in each FIFO entry; wider monitor counters are truncated.
  localparam int          TRACE_SEQ_W   = 32;

  typedef enum logic [1:0] {
    KIND_R       = 2'd0,
    KIND_I       = 2'd1,
    KIND_ILLEGAL = 2'd2,
    KIND_EXIT    = 2'd3
  } trace_kind_e;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } mon_state_e;

  typedef struct packed {
    logic [TRACE_SEQ_W-1:0] seq;
    logic [31:0]            pc;
    logic [31:0]            instr;
    trace_kind_e            kind;
    logic [4:0]             dst;
    logic [31:0]            dst_val;
  } trace_rec_t;

  // EXIT beats the decode flags: a syscall is also R-type.
  function automatic trace_kind_e classify(input logic [31:0] instr,
                                           input logic [31:0] v0,
                                           input logic        is_r,
                                           input logic        is_i);
    if (instr == SYSCALL_INSTR && v0 == EXIT_CODE) return KIND_EXIT;
    else if (is_r)                                 return KIND_R;
    else if (is_i)                                 return KIND_I;
    else                                           return KIND_ILLEGAL;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records; a push while full is accepted only if a pop frees the slot.
module trace_fifo
  import mips_trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  trace_rec_t    i_rec,
  input  logic          i_pop,
  output trace_rec_t    o_rec,
  output logic          o_full,
  output logic          o_empty,
  output logic [LW-1:0] o_level
);

  trace_rec_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the level counter decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_rec;
  end

  assign o_rec   = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/mips_retire_monitor.sv
// Captures retired-instruction records, classifies them, buffers them and streams them to a checker.
//   state | meaning
//   RUN   | accepting retire records
//   DRAIN | exit/illegal seen; retires ignored, FIFO draining
//   DONE  | FIFO emptied after exit/illegal; held until reset
module mips_retire_monitor
  import mips_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic                     ret_is_r,
  input  logic                     ret_is_i,
  input  logic                     ret_wr_en,
  input  logic [4:0]               ret_dst,
  input  logic [31:0]              ret_dst_val,
  input  logic [31:0]              ret_v0,
  output logic                     trc_valid,
  input  logic                     trc_ready,
  output logic [SEQ_W-1:0]         trc_seq,
  output logic [31:0]              trc_pc,
  output logic [31:0]              trc_instr,
  output logic [1:0]               trc_kind,
  output logic [4:0]               trc_dst,
  output logic [31:0]              trc_dst_val,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic                     err_illegal,
  output logic                     test_done
);

  mon_state_e       r_state;
  mon_state_e       w_state_nxt;
  logic [SEQ_W-1:0] r_seq;
  logic             r_overflow;
  logic [15:0]      r_drop_cnt;
  logic             r_err_illegal;

  trace_kind_e      w_kind;
  trace_rec_t       w_rec;
  trace_rec_t       w_head;
  logic             w_push_req;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  assign w_kind     = classify(ret_instr, ret_v0, ret_is_r, ret_is_i);
  assign w_push_req = (r_state == RUN) && ret_valid;
  assign w_pop      = trc_valid && trc_ready;
  assign w_drop     = w_push_req && w_full && !w_pop;

  always_comb begin
    w_rec         = '0;
    w_rec.seq     = TRACE_SEQ_W'(r_seq);
    w_rec.pc      = ret_pc;
    w_rec.instr   = ret_instr;
    w_rec.kind    = w_kind;
    w_rec.dst     = ret_wr_en ? ret_dst     : 5'd0;
    w_rec.dst_val = ret_wr_en ? ret_dst_val : 32'd0;
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push_req),
    .i_rec   (w_rec),
    .i_pop   (w_pop),
    .o_rec   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_push_req && (w_kind == KIND_EXIT || w_kind == KIND_ILLEGAL))
          w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_empty) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = RUN;
    endcase
  end

  // Dropped records still consume a sequence number and still raise the illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seq         <= '0;
      r_overflow    <= 1'b0;
      r_drop_cnt    <= '0;
      r_err_illegal <= 1'b0;
    end else begin
      if (w_push_req) r_seq <= r_seq + 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_push_req && w_kind == KIND_ILLEGAL) r_err_illegal <= 1'b1;
    end
  end

  assign trc_valid   = !w_empty;
  assign trc_seq     = trc_valid ? SEQ_W'(w_head.seq) : '0;
  assign trc_pc      = trc_valid ? w_head.pc          : 32'd0;
  assign trc_instr   = trc_valid ? w_head.instr       : 32'd0;
  assign trc_kind    = trc_valid ? w_head.kind        : 2'd0;
  assign trc_dst     = trc_valid ? w_head.dst         : 5'd0;
  assign trc_dst_val = trc_valid ? w_head.dst_val     : 32'd0;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;
  assign err_illegal = r_err_illegal;
  assign test_done   = (r_state == DONE);

endmodule

// File: tb/tb_mips_retire_monitor.sv
// Directed self-checking bench for mips_retire_monitor (DEPTH=16, SEQ_W=32).
module tb_mips_retire_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ret_valid = 1'b0;
  logic [31:0] ret_pc = '0;
  logic [31:0] ret_instr = '0;
  logic        ret_is_r = 1'b0;
  logic        ret_is_i = 1'b0;
  logic        ret_wr_en = 1'b0;
  logic [4:0]  ret_dst = '0;
  logic [31:0] ret_dst_val = '0;
  logic [31:0] ret_v0 = '0;
  logic        trc_valid;
  logic        trc_ready = 1'b0;
  logic [31:0] trc_seq;
  logic [31:0] trc_pc;
  logic [31:0] trc_instr;
  logic [1:0]  trc_kind;
  logic [4:0]  trc_dst;
  logic [31:0] trc_dst_val;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        err_illegal;
  logic        test_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_retire_monitor #(.DEPTH(16), .SEQ_W(32)) dut (
    .clk(clk), .reset(reset), .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_instr(ret_instr),
    .ret_is_r(ret_is_r), .ret_is_i(ret_is_i), .ret_wr_en(ret_wr_en), .ret_dst(ret_dst),
    .ret_dst_val(ret_dst_val), .ret_v0(ret_v0), .trc_valid(trc_valid), .trc_ready(trc_ready),
    .trc_seq(trc_seq), .trc_pc(trc_pc), .trc_instr(trc_instr), .trc_kind(trc_kind),
    .trc_dst(trc_dst), .trc_dst_val(trc_dst_val), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .err_illegal(err_illegal), .test_done(test_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ret_valid = 1'b0; trc_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic [31:0] instr, input logic is_r,
                        input logic is_i, input logic wr, input logic [4:0] dst,
                        input logic [31:0] val, input logic [31:0] v0);
    ret_pc = pc; ret_instr = instr; ret_is_r = is_r; ret_is_i = is_i;
    ret_wr_en = wr; ret_dst = dst; ret_dst_val = val; ret_v0 = v0;
    ret_valid = 1'b1;
    tick();
    ret_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({trc_valid, level, overflow, drop_cnt, err_illegal, test_done} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got v=%0b lvl=%0d ov=%0b drop=%0d ill=%0b done=%0b expected all 0",
               trc_valid, level, overflow, drop_cnt, err_illegal, test_done);
    end
    n_checks++;
    if ({trc_seq, trc_pc, trc_instr, trc_kind, trc_dst, trc_dst_val} !== 135'd0) begin
      n_fail++;
      $display("FAIL reset_trc: got seq=%0h pc=%0h instr=%0h expected 0", trc_seq, trc_pc, trc_instr);
    end
  endtask

  task automatic test_basic();
    do_reset();
    trc_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire(32'h0040_0000 + 32'(i * 4), 32'h0022_1820 + 32'(i), 1'b1, 1'b0, (i != 2),
             5'(i + 3), 32'h100 + 32'(i), 32'd0);
      n_checks++;
      if (trc_valid !== 1'b1 || trc_seq !== 32'(i) || trc_kind !== 2'd0 || level !== 5'd1 ||
          trc_pc !== 32'h0040_0000 + 32'(i * 4)) begin
        n_fail++;
        $display("FAIL basic_rec%0d: got v=%0b seq=%0d kind=%0d lvl=%0d pc=%0h expected v=1 seq=%0d kind=0 lvl=1",
                 i, trc_valid, trc_seq, trc_kind, level, trc_pc, i);
      end
      n_checks++;
      if (i < 2 && (trc_dst !== 5'(i + 3) || trc_dst_val !== 32'h100 + 32'(i))) begin
        n_fail++;
        $display("FAIL basic_dst%0d: got dst=%0d val=%0h expected dst=%0d val=%0h",
                 i, trc_dst, trc_dst_val, i + 3, 32'h100 + i);
      end else if (i == 2 && (trc_dst !== 5'd0 || trc_dst_val !== 32'd0)) begin
        n_fail++;
        $display("FAIL basic_nowrite: got dst=%0d val=%0h expected 0 0", trc_dst, trc_dst_val);
      end
    end
    tick();
    n_checks++;
    if (level !== 5'd0 || trc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_empty: got lvl=%0d v=%0b expected 0 0", level, trc_valid);
    end
    trc_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++)
      retire(32'(i * 4), 32'h0000_0020, 1'b1, 1'b0, 1'b1, 5'd1, 32'(i), 32'd0);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL overflow_state: got lvl=%0d ov=%0b drop=%0d expected 16 1 4", level, overflow, drop_cnt);
    end
    trc_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (trc_valid !== 1'b1 || trc_seq !== 32'(k)) begin
        n_fail++;
        $display("FAIL overflow_drain%0d: got v=%0b seq=%0d expected 1 %0d", k, trc_valid, trc_seq, k);
      end
      tick();
    end
    n_checks++;
    if (level !== 5'd0 || trc_valid !== 1'b0 || drop_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL overflow_end: got lvl=%0d v=%0b drop=%0d expected 0 0 4", level, trc_valid, drop_cnt);
    end
    trc_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 16; i++)
      retire(32'(i * 4), 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fill: got lvl=%0d ov=%0b expected 16 0", level, overflow);
    end
    trc_ready = 1'b1;
    retire(32'h0000_ABC0, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    n_checks++;
    if (level !== 5'd16 || overflow !== 1'b0 || drop_cnt !== 16'd0 || trc_seq !== 32'd1) begin
      n_fail++;
      $display("FAIL full_pushpop: got lvl=%0d ov=%0b drop=%0d seq=%0d expected 16 0 0 1",
               level, overflow, drop_cnt, trc_seq);
    end
    for (int k = 1; k < 16; k++) tick();
    n_checks++;
    if (trc_valid !== 1'b1 || trc_seq !== 32'd16 || trc_pc !== 32'h0000_ABC0 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL full_tail: got v=%0b seq=%0d pc=%0h lvl=%0d expected 1 16 abc0 1",
               trc_valid, trc_seq, trc_pc, level);
    end
    tick();
    trc_ready = 1'b0;
  endtask

  task automatic test_exit();
    bit seen;
    do_reset();
    retire(32'h500, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd4);
    n_checks++;
    if (trc_kind !== 2'd0 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL exit_v0_not10: got kind=%0d lvl=%0d expected 0 1", trc_kind, level);
    end
    retire(32'h504, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd10);
    retire(32'h508, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd10);
    retire(32'h50C, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd10);
    n_checks++;
    if (level !== 5'd2 || drop_cnt !== 16'd0 || test_done !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_ignore: got lvl=%0d drop=%0d done=%0b expected 2 0 0", level, drop_cnt, test_done);
    end
    trc_ready = 1'b1;
    tick();
    n_checks++;
    if (trc_kind !== 2'd3 || trc_seq !== 32'd1 || trc_pc !== 32'h504) begin
      n_fail++;
      $display("FAIL exit_rec: got kind=%0d seq=%0d pc=%0h expected 3 1 504", trc_kind, trc_seq, trc_pc);
    end
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      seen = test_done;
    end
    n_checks++;
    if (test_done !== 1'b1 || level !== 5'd0 || err_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL exit_done: got done=%0b lvl=%0d ill=%0b expected 1 0 0", test_done, level, err_illegal);
    end
    retire(32'h510, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    n_checks++;
    if (test_done !== 1'b1 || level !== 5'd0) begin
      n_fail++;
      $display("FAIL exit_sticky: got done=%0b lvl=%0d expected 1 0", test_done, level);
    end
    trc_ready = 1'b0;
  endtask

  task automatic test_illegal();
    bit seen;
    do_reset();
    trc_ready = 1'b1;
    retire(32'h600, 32'h2008_0005, 1'b0, 1'b1, 1'b1, 5'd8, 32'd5, 32'd0);
    n_checks++;
    if (trc_kind !== 2'd1 || trc_dst !== 5'd8 || trc_dst_val !== 32'd5 || err_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_itype: got kind=%0d dst=%0d val=%0d ill=%0b expected 1 8 5 0",
               trc_kind, trc_dst, trc_dst_val, err_illegal);
    end
    retire(32'h604, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    n_checks++;
    if (trc_kind !== 2'd2 || trc_seq !== 32'd1 || err_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_rec: got kind=%0d seq=%0d ill=%0b expected 2 1 1", trc_kind, trc_seq, err_illegal);
    end
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      tick();
      seen = test_done;
    end
    n_checks++;
    if (test_done !== 1'b1 || err_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_done: got done=%0b ill=%0b expected 1 1", test_done, err_illegal);
    end
    trc_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++)
      retire(32'(i * 4), 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    retire(32'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    n_checks++;
    if (level !== 5'd5 || err_illegal !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: got lvl=%0d ill=%0b expected 5 1", level, err_illegal);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (level !== 5'd0 || trc_valid !== 1'b0 || err_illegal !== 1'b0 || test_done !== 1'b0 ||
        overflow !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_clear: got lvl=%0d v=%0b ill=%0b done=%0b ov=%0b drop=%0d expected all 0",
               level, trc_valid, err_illegal, test_done, overflow, drop_cnt);
    end
    retire(32'h700, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    n_checks++;
    if (trc_seq !== 32'd0 || trc_pc !== 32'h700 || level !== 5'd1) begin
      n_fail++;
      $display("FAIL midreset_seq: got seq=%0d pc=%0h lvl=%0d expected 0 700 1", trc_seq, trc_pc, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_exit();
    test_illegal();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
